// File: rtl/pri_request_latch.sv
// Request latch and grant stage in front of a 16-bit lowest-index priority encoder.
// Latency: request pulse in cycle c -> pending c+1 -> SCAN c+2 -> grant_valid c+3.
// Backpressure: grant_valid/grant_id hold until grant_ready; requests keep latching meanwhile.
module pri_request_latch (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req_in,
  input  logic [15:0] mask_in,
  output logic [15:0] encoder_in,
  output logic        enable,
  input  logic [3:0]  binary_out,
  output logic        grant_valid,
  output logic [3:0]  grant_id,
  input  logic        grant_ready,
  output logic [15:0] pending_out,
  output logic [7:0]  miss_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_OFFER = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pending;
  logic [15:0] eligible;
  logic        any_eligible;
  logic [15:0] clr;
  logic        collide;

  assign eligible     = pending & mask_in;
  assign any_eligible = |eligible;
  assign encoder_in   = eligible;
  assign pending_out  = pending;

  // Clear the serviced bit only when SCAN actually captures a grant; an
  // all-zero vector makes the encoder report 15, which must not be cleared.
  always_comb begin
    clr = '0;
    if (state == S_SCAN && any_eligible) begin
      clr[binary_out] = 1'b1;
    end
  end

  // A request is lost when it lands on a bit that is still pending after this cycle's clear.
  assign collide = |(req_in & pending & ~clr);

  // Pending register: set wins over clear, so a re-request on the bit being granted is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | req_in;
    end
  end

  // Saturating count of cycles in which at least one request was lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_count <= '0;
    end else if (collide && miss_count != 8'hFF) begin
      miss_count <= miss_count + 8'd1;
    end
  end

  // Grant FSM with registered enable/grant outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      enable      <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_eligible) begin
            state  <= S_SCAN;
            enable <= 1'b1;
          end
        end
        S_SCAN: begin
          enable <= 1'b0;
          if (any_eligible) begin
            grant_id    <= binary_out;
            grant_valid <= 1'b1;
            state       <= S_OFFER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_OFFER: begin
          if (grant_ready) begin
            grant_valid <= 1'b0;
            if (any_eligible) begin
              state  <= S_SCAN;
              enable <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          enable      <= 1'b0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pri_request_latch.sv
module tb_pri_request_latch;

  logic        clk;
  logic        reset;
  logic [15:0] req_in;
  logic [15:0] mask_in;
  logic [15:0] encoder_in;
  logic        enable;
  logic [3:0]  binary_out;
  logic        grant_valid;
  logic [3:0]  grant_id;
  logic        grant_ready;
  logic [15:0] pending_out;
  logic [7:0]  miss_count;

  int total = 0;
  int bad   = 0;

  pri_request_latch dut (
    .clk         (clk),
    .reset       (reset),
    .req_in      (req_in),
    .mask_in     (mask_in),
    .encoder_in  (encoder_in),
    .enable      (enable),
    .binary_out  (binary_out),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_ready (grant_ready),
    .pending_out (pending_out),
    .miss_count  (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16-bit priority encoder: lowest set index, 15 when nothing is set.
  always_comb begin
    binary_out = 4'hF;
    for (int i = 15; i >= 0; i--) begin
      if (encoder_in[i]) binary_out = i[3:0];
    end
  end

  // Reference model: pending set, whether a scan is happening this cycle,
  // the outstanding grant (if any) and the miss counter.
  logic [15:0] m_pend;
  logic        m_scan;
  logic        m_gv;
  logic [3:0]  m_gid;
  int          m_miss;

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: predict from pre-edge inputs, then compare after the edge.
  task automatic step();
    logic [15:0] vec, clr, lost, n_pend;
    logic        n_scan, n_gv;
    logic [3:0]  n_gid;
    int          n_miss, idx;
    vec    = m_pend & mask_in;
    clr    = '0;
    n_pend = m_pend;
    n_scan = m_scan;
    n_gv   = m_gv;
    n_gid  = m_gid;
    n_miss = m_miss;
    if (reset) begin
      n_pend = '0; n_scan = 1'b0; n_gv = 1'b0; n_gid = '0; n_miss = 0;
    end else begin
      if (m_gv) begin
        if (grant_ready) begin
          n_gv   = 1'b0;
          n_scan = (vec != 0);
        end
      end else if (m_scan) begin
        n_scan = 1'b0;
        if (vec != 0) begin
          idx      = lowest(vec);
          n_gid    = idx[3:0];
          clr[idx] = 1'b1;
          n_gv     = 1'b1;
        end
      end else begin
        n_scan = (vec != 0);
      end
      lost   = req_in & m_pend & ~clr;
      n_pend = (m_pend & ~clr) | req_in;
      if (lost != 0 && m_miss < 255) n_miss = m_miss + 1;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_scan = n_scan; m_gv = n_gv; m_gid = n_gid; m_miss = n_miss;
    check("pending_out", {16'h0, pending_out}, {16'h0, m_pend});
    check("grant_valid", {31'h0, grant_valid}, {31'h0, m_gv});
    if (m_gv) check("grant_id", {28'h0, grant_id}, {28'h0, m_gid});
    check("enable", {31'h0, enable}, {31'h0, m_scan});
    check("miss_count", {24'h0, miss_count}, m_miss);
    check("encoder_in", {16'h0, encoder_in}, {16'h0, m_pend & mask_in});
  endtask

  task automatic cyc(input logic [15:0] rq, input logic [15:0] mk, input logic rdy, input logic rst);
    req_in = rq; mask_in = mk; grant_ready = rdy; reset = rst;
    step();
  endtask

  initial begin
    m_pend = '0; m_scan = 1'b0; m_gv = 1'b0; m_gid = '0; m_miss = 0;
    req_in = '0; mask_in = 16'hFFFF; grant_ready = 1'b1; reset = 1'b1;

    // Reset state
    cyc(16'h0, 16'hFFFF, 1'b1, 1'b1);
    cyc(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    check("rst_pending", {16'h0, pending_out}, 32'h0);
    check("rst_gv", {31'h0, grant_valid}, 32'h0);
    check("rst_gid", {28'h0, grant_id}, 32'h0);
    check("rst_miss", {24'h0, miss_count}, 32'h0);

    // Single request: grant 4 three cycles after the pulse
    cyc(16'h0010, 16'hFFFF, 1'b1, 1'b0);
    cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    check("single_gv", {31'h0, grant_valid}, 32'h1);
    check("single_gid", {28'h0, grant_id}, 32'h4);
    check("single_pend", {16'h0, pending_out}, 32'h0);
    repeat (3) cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);

    // Priority and drain
    cyc(16'h8421, 16'hFFFF, 1'b1, 1'b0);
    repeat (3) cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    check("prio_first", {28'h0, grant_id}, 32'h0);
    repeat (2) cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    check("prio_second", {28'h0, grant_id}, 32'h5);
    repeat (6) cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    check("prio_empty", {16'h0, pending_out}, 32'h0);

    // Backpressure
    cyc(16'h0006, 16'hFFFF, 1'b0, 1'b0);
    repeat (12) cyc(16'h0, 16'hFFFF, 1'b0, 1'b0);
    check("bp_gv", {31'h0, grant_valid}, 32'h1);
    check("bp_gid", {28'h0, grant_id}, 32'h1);
    cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    check("bp_next_gid", {28'h0, grant_id}, 32'h2);
    repeat (3) cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);

    // Masking
    cyc(16'h0003, 16'hFFFE, 1'b1, 1'b0);
    repeat (6) cyc(16'h0, 16'hFFFE, 1'b1, 1'b0);
    check("mask_held", {16'h0, pending_out}, 32'h1);
    repeat (4) cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    check("mask_empty", {16'h0, pending_out}, 32'h0);
    cyc(16'h0001, 16'hFFFF, 1'b1, 1'b0);
    cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);
    cyc(16'h0, 16'h0000, 1'b1, 1'b0);
    check("mask_drop_gv", {31'h0, grant_valid}, 32'h0);
    check("mask_drop_pend", {16'h0, pending_out}, 32'h1);
    repeat (4) cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);

    // Collision saturation
    repeat (300) cyc(16'h0008, 16'h0000, 1'b1, 1'b0);
    check("miss_sat", {24'h0, miss_count}, 32'hFF);
    cyc(16'h0, 16'hFFFF, 1'b1, 1'b1);
    // Re-request during the SCAN that grants bit 2
    cyc(16'h0004, 16'hFFFF, 1'b0, 1'b0);
    cyc(16'h0, 16'hFFFF, 1'b0, 1'b0);
    cyc(16'h0004, 16'hFFFF, 1'b0, 1'b0);
    check("rereq_pend", {16'h0, pending_out}, 32'h4);
    check("rereq_miss", {24'h0, miss_count}, 32'h0);
    repeat (6) cyc(16'h0, 16'hFFFF, 1'b1, 1'b0);

    // Reset mid-OFFER
    cyc(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    repeat (3) cyc(16'h0, 16'hFFFF, 1'b0, 1'b0);
    cyc(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    check("mid_rst_gv", {31'h0, grant_valid}, 32'h0);
    check("mid_rst_pend", {16'h0, pending_out}, 32'h0);
    check("mid_rst_en", {31'h0, enable}, 32'h0);
    check("mid_rst_gid", {28'h0, grant_id}, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] rq, mk;
      rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
      mk = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      cyc(rq, mk, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
